// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared types and geometry for the plotter render scheduler
package render_pkg;

  localparam int HOR_ACTIVE_PIXELS = 640;
  localparam int VER_ACTIVE_PIXELS = 480;
  localparam int FB_ADDR_WIDTH     = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR_START,
    ST_CLR_GUARD,
    ST_CLR_WAIT,
    ST_PLOT_START,
    ST_PLOT_GUARD,
    ST_PLOT_WAIT,
    ST_SWAP_WAIT,
    ST_SWAP
  } state_e;

endpackage

// File: rtl/fb_write_mux.sv
// rtl/fb_write_mux.sv - frame_buffer write-port owner select and conflict detect
module fb_write_mux
  import render_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH
) (
  input  state_e                state_i,
  input  logic                  fill_we_i,
  input  logic [ADDR_WIDTH-1:0] fill_addr_i,
  input  logic                  fill_data_i,
  input  logic                  line_we_i,
  input  logic [ADDR_WIDTH-1:0] line_addr_i,
  input  logic                  line_data_i,
  output logic                  fb_we_o,
  output logic [ADDR_WIDTH-1:0] fb_addr_o,
  output logic                  fb_data_o,
  output logic                  conflict_o
);

  logic fill_own;
  logic line_own;

  always_comb begin
    fill_own   = (state_i == ST_CLR_START) || (state_i == ST_CLR_GUARD) ||
                 (state_i == ST_CLR_WAIT);
    line_own   = (state_i == ST_PLOT_START) || (state_i == ST_PLOT_GUARD) ||
                 (state_i == ST_PLOT_WAIT);
    fb_we_o    = 1'b0;
    fb_addr_o  = '0;
    fb_data_o  = 1'b0;
    conflict_o = 1'b0;
    if (fill_own) begin
      fb_we_o    = fill_we_i;
      fb_addr_o  = fill_addr_i;
      fb_data_o  = fill_data_i;
      conflict_o = line_we_i;
    end else if (line_own) begin
      fb_we_o    = line_we_i;
      fb_addr_o  = line_addr_i;
      fb_data_o  = line_data_i;
      conflict_o = fill_we_i;
    end else begin
      // Nobody owns the port outside a drawing phase, so any write is stray.
      conflict_o = fill_we_i | line_we_i;
    end
  end

endmodule

// File: rtl/render_scheduler.sv
// rtl/render_scheduler.sv - frame sequencer: clear, plot, wait for vblank, swap
module render_scheduler
  import render_pkg::*;
#(
  parameter int ADDR_WIDTH     = 19,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int TIMEOUT_WIDTH  = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redraw_req,
  input  logic                  vblank,
  output logic                  fill_drawer_start,
  input  logic                  fill_drawer_ready,
  output logic                  logic_start,
  input  logic                  logic_ready,
  input  logic                  fill_we,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic                  fill_data,
  input  logic                  line_we,
  input  logic [ADDR_WIDTH-1:0] line_addr,
  input  logic                  line_data,
  output logic                  fb_write_enable,
  output logic [ADDR_WIDTH-1:0] fb_write_addr,
  output logic                  fb_write_data,
  output logic                  swap,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  conflict_err
);

  state_e                   state_q;
  logic                     pending_q;
  logic [TIMEOUT_WIDTH-1:0] cnt_q;
  logic                     fill_start_q;
  logic                     logic_start_q;
  logic                     swap_q;
  logic                     busy_q;
  logic                     timeout_err_q;
  logic                     conflict_err_q;
  logic                     conflict;
  logic                     timeout_hit;

  // Fires on the cycle whose increment would bring the count to TIMEOUT_CYCLES.
  assign timeout_hit = (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      pending_q      <= 1'b0;
      cnt_q          <= '0;
      fill_start_q   <= 1'b0;
      logic_start_q  <= 1'b0;
      swap_q         <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      conflict_err_q <= 1'b0;
    end else begin
      fill_start_q  <= 1'b0;
      logic_start_q <= 1'b0;
      swap_q        <= 1'b0;
      if (conflict) conflict_err_q <= 1'b1;
      if (redraw_req && (state_q != ST_IDLE)) pending_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (redraw_req || pending_q) begin
            state_q      <= ST_CLR_START;
            pending_q    <= 1'b0;
            fill_start_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_CLR_START: state_q <= ST_CLR_GUARD;
        ST_CLR_GUARD: begin
          state_q <= ST_CLR_WAIT;
          cnt_q   <= '0;
        end
        ST_CLR_WAIT: begin
          if (fill_drawer_ready || timeout_hit) begin
            if (!fill_drawer_ready) timeout_err_q <= 1'b1;
            state_q       <= ST_PLOT_START;
            logic_start_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + TIMEOUT_WIDTH'(1);
          end
        end
        ST_PLOT_START: state_q <= ST_PLOT_GUARD;
        ST_PLOT_GUARD: begin
          state_q <= ST_PLOT_WAIT;
          cnt_q   <= '0;
        end
        ST_PLOT_WAIT: begin
          if (logic_ready || timeout_hit) begin
            if (!logic_ready) timeout_err_q <= 1'b1;
            state_q <= ST_SWAP_WAIT;
          end else begin
            cnt_q <= cnt_q + TIMEOUT_WIDTH'(1);
          end
        end
        ST_SWAP_WAIT: begin
          if (vblank) begin
            state_q <= ST_SWAP;
            swap_q  <= 1'b1;
          end
        end
        ST_SWAP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  fb_write_mux #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_fb_write_mux (
    .state_i    (state_q),
    .fill_we_i  (fill_we),
    .fill_addr_i(fill_addr),
    .fill_data_i(fill_data),
    .line_we_i  (line_we),
    .line_addr_i(line_addr),
    .line_data_i(line_data),
    .fb_we_o    (fb_write_enable),
    .fb_addr_o  (fb_write_addr),
    .fb_data_o  (fb_write_data),
    .conflict_o (conflict)
  );

  assign fill_drawer_start = fill_start_q;
  assign logic_start       = logic_start_q;
  assign swap              = swap_q;
  assign busy              = busy_q;
  assign timeout_err       = timeout_err_q;
  assign conflict_err      = conflict_err_q;

endmodule

// File: tb/tb_render_scheduler.sv
// tb/tb_render_scheduler.sv - directed bench for render_scheduler
module tb_render_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        redraw_req;
  logic        vblank;
  logic        fill_drawer_start;
  logic        fill_drawer_ready;
  logic        logic_start;
  logic        logic_ready;
  logic        fill_we;
  logic [18:0] fill_addr;
  logic        fill_data;
  logic        line_we;
  logic [18:0] line_addr;
  logic        line_data;
  logic        fb_write_enable;
  logic [18:0] fb_write_addr;
  logic        fb_write_data;
  logic        swap;
  logic        busy;
  logic        timeout_err;
  logic        conflict_err;

  render_scheduler #(
    .ADDR_WIDTH(19),
    .TIMEOUT_CYCLES(100),
    .TIMEOUT_WIDTH(21)
  ) dut (
    .clk(clk), .rst(rst), .redraw_req(redraw_req), .vblank(vblank),
    .fill_drawer_start(fill_drawer_start), .fill_drawer_ready(fill_drawer_ready),
    .logic_start(logic_start), .logic_ready(logic_ready),
    .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data),
    .line_we(line_we), .line_addr(line_addr), .line_data(line_data),
    .fb_write_enable(fb_write_enable), .fb_write_addr(fb_write_addr),
    .fb_write_data(fb_write_data), .swap(swap), .busy(busy),
    .timeout_err(timeout_err), .conflict_err(conflict_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    int          phase;
    logic        fwe;
    logic [18:0] faddr;
    logic        fdata;
    logic        lwe;
    logic [18:0] laddr;
    logic        ldata;
    logic        ewe;
    logic [18:0] eaddr;
    logic        edata;
    logic        econf;
  } vec_t;

  vec_t vecs[7];

  int fill_cnt, logic_cnt, fill_lat, logic_lat, swaps;
  bit fs_m, ls_m, terr_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Drawer stubs: ready drops the cycle after start is seen, returns after *_lat cycles.
  task automatic tick();
    @(negedge clk);
    fs_m   = fill_drawer_start;
    ls_m   = logic_start;
    terr_m = timeout_err;
    if (swap) swaps++;
    @(posedge clk);
    #1;
    if (fs_m) begin
      fill_drawer_ready = 1'b0;
      fill_cnt = fill_lat;
    end else if (fill_cnt > 0) begin
      fill_cnt--;
      if (fill_cnt == 0) fill_drawer_ready = 1'b1;
    end
    if (ls_m) begin
      logic_ready = 1'b0;
      logic_cnt = logic_lat;
    end else if (logic_cnt > 0) begin
      logic_cnt--;
      if (logic_cnt == 0) logic_ready = 1'b1;
    end
  endtask

  task automatic zero_inputs();
    redraw_req = 1'b0; vblank = 1'b0;
    fill_drawer_ready = 1'b0; logic_ready = 1'b0;
    fill_we = 1'b0; fill_addr = '0; fill_data = 1'b0;
    line_we = 1'b0; line_addr = '0; line_data = 1'b0;
    fill_cnt = 0; logic_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    zero_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic goto_phase(input int p);
    fill_we = 1'b0; line_we = 1'b0;
    case (p)
      1: begin
        redraw_req = 1'b1; step(); redraw_req = 1'b0; step(); step();
      end
      2: begin
        fill_drawer_ready = 1'b1; step(); fill_drawer_ready = 1'b0; step(); step();
      end
      3: begin
        logic_ready = 1'b1; step(); logic_ready = 1'b0;
      end
      default: begin
        vblank = 1'b1; step(); vblank = 1'b0; step();
      end
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cur, early, cnt, sw;
    bit seen;

    vecs[0] = '{0, 1'b0, 19'h00000, 1'b0, 1'b0, 19'h00000, 1'b0, 1'b0, 19'h00000, 1'b0, 1'b0};
    vecs[1] = '{1, 1'b1, 19'h00010, 1'b1, 1'b0, 19'h00020, 1'b0, 1'b1, 19'h00010, 1'b1, 1'b0};
    vecs[2] = '{1, 1'b1, 19'h00010, 1'b0, 1'b1, 19'h00020, 1'b1, 1'b1, 19'h00010, 1'b0, 1'b1};
    vecs[3] = '{2, 1'b1, 19'h00010, 1'b0, 1'b1, 19'h00020, 1'b1, 1'b1, 19'h00020, 1'b1, 1'b1};
    vecs[4] = '{2, 1'b0, 19'h00010, 1'b0, 1'b1, 19'h7FFFF, 1'b1, 1'b1, 19'h7FFFF, 1'b1, 1'b1};
    vecs[5] = '{3, 1'b1, 19'h00010, 1'b1, 1'b1, 19'h00020, 1'b1, 1'b0, 19'h00000, 1'b0, 1'b1};
    vecs[6] = '{4, 1'b1, 19'h00010, 1'b1, 1'b1, 19'h00020, 1'b1, 1'b0, 19'h00000, 1'b0, 1'b1};

    // Reset state
    rst = 1'b1;
    zero_inputs();
    step(); step();
    mid();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_swap", 32'(swap), 32'd0);
    chk("rst_fill_start", 32'(fill_drawer_start), 32'd0);
    chk("rst_logic_start", 32'(logic_start), 32'd0);
    chk("rst_errs", 32'({timeout_err, conflict_err}), 32'd0);
    chk("rst_fb_we", 32'(fb_write_enable), 32'd0);
    step();
    rst = 1'b0;

    // Nominal frame
    do_reset();
    fill_drawer_ready = 1'b1; logic_ready = 1'b1;
    for (int i = 0; i < 9; i++) step();
    redraw_req = 1'b1; mid();
    chk("nom_start_early", 32'(fill_drawer_start), 32'd0);
    step(); redraw_req = 1'b0; mid();
    chk("nom_fill_start", 32'(fill_drawer_start), 32'd1);
    chk("nom_busy", 32'(busy), 32'd1);
    step(); fill_drawer_ready = 1'b0; mid();
    chk("nom_fill_start_one", 32'(fill_drawer_start), 32'd0);
    early = 0;
    for (int c = 3; c <= 22; c++) begin
      step();
      fill_drawer_ready = (c == 22);
      mid();
      if (logic_start) early++;
    end
    chk("nom_logic_early", 32'(early), 32'd0);
    step(); fill_drawer_ready = 1'b1; mid();
    chk("nom_logic_start", 32'(logic_start), 32'd1);
    step(); logic_ready = 1'b0;
    for (int c = 25; c <= 34; c++) begin
      step();
      logic_ready = (c == 34);
    end
    sw = 0; cnt = 0;
    for (int c = 35; c <= 95; c++) begin
      step();
      vblank = (c >= 84 && c <= 88);
      mid();
      if (swap) begin
        sw++;
        cnt = c;
        chk("nom_busy_in_swap", 32'(busy), 32'd1);
      end
      if (c == 86) chk("nom_busy_after_swap", 32'(busy), 32'd0);
    end
    chk("nom_swap_count", 32'(sw), 32'd1);
    chk("nom_swap_cycle", 32'(cnt), 32'd85);

    // Coalescing
    do_reset();
    fill_drawer_ready = 1'b1; logic_ready = 1'b1;
    fill_lat = 5; logic_lat = 30; swaps = 0;
    redraw_req = 1'b1; tick(); redraw_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (ls_m) seen = 1;
    end
    chk("coal_logic_start_seen", 32'(seen), 32'd1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) tick();
      redraw_req = 1'b1; tick(); redraw_req = 1'b0;
    end
    for (int i = 0; i < 25; i++) tick();
    chk("coal_no_swap_yet", 32'(swaps), 32'd0);
    vblank = 1'b1; tick();
    vblank = 1'b0; redraw_req = 1'b1; tick(); redraw_req = 1'b0;
    chk("coal_first_swap", 32'(swaps), 32'd1);
    vblank = 1'b1;
    for (int i = 0; i < 300 && swaps < 2; i++) tick();
    vblank = 1'b0;
    chk("coal_second_swap", 32'(swaps), 32'd2);
    for (int i = 0; i < 30; i++) tick();
    chk("coal_no_third", 32'(swaps), 32'd2);
    chk("coal_idle", 32'(busy), 32'd0);
    chk("coal_no_timeout", 32'(timeout_err), 32'd0);

    // Write-port arbitration table
    do_reset();
    cur = 0;
    foreach (vecs[i]) begin
      if (vecs[i].phase != cur) begin
        goto_phase(vecs[i].phase);
        cur = vecs[i].phase;
      end
      fill_we = vecs[i].fwe; fill_addr = vecs[i].faddr; fill_data = vecs[i].fdata;
      line_we = vecs[i].lwe; line_addr = vecs[i].laddr; line_data = vecs[i].ldata;
      mid();
      chk($sformatf("arb%0d_we", i), 32'(fb_write_enable), 32'(vecs[i].ewe));
      chk($sformatf("arb%0d_addr", i), 32'(fb_write_addr), 32'(vecs[i].eaddr));
      chk($sformatf("arb%0d_data", i), 32'(fb_write_data), 32'(vecs[i].edata));
      step();
      chk($sformatf("arb%0d_conflict", i), 32'(conflict_err), 32'(vecs[i].econf));
    end
    fill_we = 1'b0; line_we = 1'b0;

    // Timeout in plot phase
    do_reset();
    fill_drawer_ready = 1'b1; logic_ready = 1'b1;
    fill_lat = 5; logic_lat = 100000; swaps = 0;
    redraw_req = 1'b1; tick(); redraw_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (ls_m) seen = 1;
    end
    chk("to_logic_start_seen", 32'(seen), 32'd1);
    for (int k = 1; k <= 102; k++) begin
      tick();
      if (k == 101) chk("to_err_before", 32'(terr_m), 32'd0);
      if (k == 102) chk("to_err_at", 32'(terr_m), 32'd1);
    end
    vblank = 1'b1;
    for (int i = 0; i < 5 && swaps == 0; i++) tick();
    vblank = 1'b0;
    chk("to_swap_issued", 32'(swaps), 32'd1);
    chk("to_err_sticky", 32'(timeout_err), 32'd1);

    // Instant ready: guards must hide ready still held from the previous job
    do_reset();
    fill_drawer_ready = 1'b1; logic_ready = 1'b1; vblank = 1'b1;
    redraw_req = 1'b1; step(); redraw_req = 1'b0; mid();
    chk("inst_fill_start", 32'(fill_drawer_start), 32'd1);
    early = 0;
    for (int c = 2; c <= 8; c++) begin
      step();
      fill_drawer_ready = !(c >= 3 && c <= 7);
      mid();
      if (logic_start) early++;
    end
    chk("inst_logic_early", 32'(early), 32'd0);
    step(); mid();
    chk("inst_logic_start", 32'(logic_start), 32'd1);
    early = 0;
    for (int c = 10; c <= 17; c++) begin
      step();
      logic_ready = !(c >= 11 && c <= 15);
      mid();
      if (swap) early++;
    end
    chk("inst_swap_early", 32'(early), 32'd0);
    step(); mid();
    chk("inst_swap", 32'(swap), 32'd1);
    vblank = 1'b0;

    // Reset mid-frame
    do_reset();
    redraw_req = 1'b1; step(); redraw_req = 1'b0; step(); step();
    line_we = 1'b1; step(); line_we = 1'b0;
    redraw_req = 1'b1; step(); redraw_req = 1'b0;
    chk("mr_conflict_set", 32'(conflict_err), 32'd1);
    chk("mr_busy", 32'(busy), 32'd1);
    rst = 1'b1; step(); rst = 1'b0; mid();
    chk("mr_busy_cleared", 32'(busy), 32'd0);
    chk("mr_errs_cleared", 32'({timeout_err, conflict_err}), 32'd0);
    chk("mr_outs_zero", 32'({fill_drawer_start, logic_start, swap, fb_write_enable}), 32'd0);
    fill_drawer_ready = 1'b1; logic_ready = 1'b1; vblank = 1'b1;
    cnt = 0; sw = 0;
    for (int i = 0; i < 20; i++) begin
      step(); mid();
      if (fill_drawer_start) cnt++;
      if (swap) sw++;
    end
    chk("mr_no_pending_start", 32'(cnt), 32'd0);
    chk("mr_no_swap", 32'(sw), 32'd0);
    step();
    redraw_req = 1'b1; step(); redraw_req = 1'b0;
    sw = 0;
    for (int i = 0; i < 20; i++) begin
      mid();
      if (swap) sw++;
      step();
    end
    chk("mr_new_frame_swap", 32'(sw), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/render_scheduler.md
Name: render_scheduler

Overview:
Frame-level sequencer for the plotter render pipeline. On a redraw request it pulses fill_drawer to clear the back buffer, then starts logic to plot the expression through line_drawer. It then waits for vertical blank and pulses frame_buffer swap. It also owns the single frame_buffer write port, granting it to the fill or line drawer according to the current phase.

Parameters:
ADDR_WIDTH, 19, frame_buffer write address width (640*480 pixels).
TIMEOUT_CYCLES, 2000000, maximum cycles allowed in any wait phase before abort.
TIMEOUT_WIDTH, 21, counter width; must satisfy 2^TIMEOUT_WIDTH > TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
redraw_req  in  1  single-cycle pulse: expression changed, render a new frame
vblank  in  1  high during vertical blanking, from the VGA timing block
fill_drawer_start  out  1  one-cycle start pulse to fill_drawer
fill_drawer_ready  in  1  fill_drawer idle/done
logic_start  out  1  one-cycle start pulse to logic
logic_ready  in  1  logic idle/done
fill_we  in  1  fill_drawer write enable
fill_addr  in  ADDR_WIDTH  fill_drawer write address
fill_data  in  1  fill_drawer write data
line_we  in  1  line_drawer write enable
line_addr  in  ADDR_WIDTH  line_drawer write address
line_data  in  1  line_drawer write data
fb_write_enable  out  1  to frame_buffer
fb_write_addr  out  ADDR_WIDTH  to frame_buffer
fb_write_data  out  1  to frame_buffer
swap  out  1  one-cycle swap pulse to frame_buffer
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky: a wait phase timed out
conflict_err  out  1  sticky: a non-owner drawer asserted write enable

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0; pending=0; timeout counter=0; both sticky errors cleared. rst mid-frame aborts immediately; no swap is issued.
- States: IDLE, CLR_START, CLR_GUARD, CLR_WAIT, PLOT_START, PLOT_GUARD, PLOT_WAIT, SWAP_WAIT, SWAP.
- Transitions:
  - IDLE: on redraw_req or pending, go to CLR_START and clear pending.
  - CLR_START: fill_drawer_start=1 for exactly 1 cycle, then CLR_GUARD.
  - CLR_GUARD: ready is ignored for 1 cycle, because sub-blocks drop ready the cycle after sampling start. Then CLR_WAIT.
  - CLR_WAIT: on fill_drawer_ready=1, go to PLOT_START.
  - PLOT_START, PLOT_GUARD, PLOT_WAIT: identical pattern using logic_start and logic_ready.
  - PLOT_WAIT: on ready, go to SWAP_WAIT.
  - SWAP_WAIT: on vblank=1, go to SWAP. If vblank is already high on entry, advance the next cycle.
  - SWAP: swap=1 for 1 cycle, then IDLE.
- Start-to-start latency: redraw_req in cycle N gives fill_drawer_start=1 in cycle N+1. Ready sampled in cycle M gives logic_start in M+1.
- redraw_req outside IDLE sets pending. Multiple requests coalesce into one rerender after the current SWAP. redraw_req in the same cycle as SWAP→IDLE is kept as pending, never lost.
- Timeout: the counter clears on entry to each *_WAIT state and increments each cycle in it. When it reaches TIMEOUT_CYCLES:
  - set timeout_err;
  - advance as if ready had been seen (CLR_WAIT→PLOT_START, PLOT_WAIT→SWAP_WAIT);
  - SWAP_WAIT is not subject to timeout.
- Write arbitration is combinational from the registered state.
  - CLR_START..CLR_WAIT: fb_* = fill_*.
  - PLOT_START..PLOT_WAIT: fb_* = line_*.
  - All other states: fb_write_enable=0 and fb_write_addr/data=0.
  - A non-owner *_we=1 is dropped and sets conflict_err. The owner's write still passes.
- Sticky errors clear only on rst.
- busy = (state != IDLE).

Decomposition:
- Package render_pkg: state enum (4-bit), HOR_ACTIVE_PIXELS=640, VER_ACTIVE_PIXELS=480, derived ADDR_WIDTH.
- One natural sub-module: fb_write_mux (owner select, 2:1 write-port mux, conflict detect). The FSM, pending flag and timeout counter stay in the top level.

Test Plan:
- Nominal frame: stub ready drops 1 cycle after start. Pulse redraw_req in cycle 10 → fill_drawer_start in cycle 11. Fill ready after 20 cycles → logic_start next cycle. Logic done, vblank raised 50 cycles later → exactly one swap pulse, busy falls with it.
- Coalescing: three redraw_req pulses during PLOT_WAIT, plus one coinciding with SWAP → exactly one extra full frame (2 swaps total), then IDLE.
- Arbitration: both fill_we and line_we held at 1 with addresses 0x00010 and 0x00020. In clear phase fb_write_addr=0x00010 and conflict_err=1. In IDLE fb_write_enable=0.
- Timeout: TIMEOUT_CYCLES=100, logic_ready stuck 0 → PLOT_START at T, timeout_err=1 at T+102, swap still issued on the next vblank.
- Instant ready: stub keeps ready=1 for 1 cycle after start → guard cycle prevents early advance; logic_start appears only after the stub completes.
- Reset mid-operation: rst during CLR_WAIT → next cycle state IDLE, all outputs 0, pending and errors cleared, no swap until a new redraw_req.
